// File: rtl/fibo_sequencer_pkg.sv
// fibo_sequencer_pkg: opcodes, state encoding and step order shared by the sequencer and the decoder.
package fibo_sequencer_pkg;
   localparam int SIZE_DEF = 4;
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_LOAD = 3'b100;
   localparam logic [2:0] OP_OUT  = 3'b101;
   typedef enum logic [2:0] {IDLE, LD0, LD1, OUT0, OUT1, ADD, OUT, DONE} state_t;
   function automatic state_t step(state_t s);
      case (s)
         LD0:     step = LD1;
         LD1:     step = OUT0;
         OUT0:    step = OUT1;
         OUT1:    step = ADD;
         ADD:     step = OUT;
         OUT:     step = ADD;
         default: step = IDLE;
      endcase
   endfunction
endpackage

// File: rtl/fibo_sequencer.sv
// fibo_sequencer: issues LOAD/ADD/OUT instructions that make a downstream register file emit n Fibonacci terms.
module fibo_sequencer
   import fibo_sequencer_pkg::*;
#(
   parameter int SIZE = SIZE_DEF,
   parameter int NW   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [NW-1:0]   n,
   input  logic            ready,
   output logic            instr_valid,
   output logic [SIZE-2:0] opcode,
   output logic [SIZE-3:0] operand1,
   output logic [SIZE-3:0] operand2,
   output logic [NW-1:0]   load_value,
   output logic            busy,
   output logic            done
);
   typedef struct packed {
      logic            v;
      logic [SIZE-2:0] op;
      logic [SIZE-3:0] a;
      logic [SIZE-3:0] b;
      logic [NW-1:0]   ld;
   } instr_t;
   localparam logic [SIZE-3:0] R0 = '0;
   localparam logic [SIZE-3:0] R1 = (SIZE-2)'(1);
   state_t          state, nxt;
   instr_t          ins;
   logic [NW-1:0]   n_reg, cnt, cnt_inc;
   logic [SIZE-3:0] ra, rb, ra_n, rb_n;
   logic            is_out, fin;
   function automatic instr_t emit(state_t s, logic [SIZE-3:0] a, logic [SIZE-3:0] b);
      emit = '0;
      emit.v = 1'b1;
      case (s)
         LD0:     emit.op = (SIZE-1)'(OP_LOAD);
         LD1:     begin emit.op = (SIZE-1)'(OP_LOAD); emit.a = R1; emit.ld = NW'(1); end
         OUT0:    emit.op = (SIZE-1)'(OP_OUT);
         OUT1:    begin emit.op = (SIZE-1)'(OP_OUT); emit.a = R1; end
         ADD:     begin emit.op = (SIZE-1)'(OP_ADD); emit.a = a; emit.b = b; end
         OUT:     begin emit.op = (SIZE-1)'(OP_OUT); emit.a = a; end
         default: emit = '0;
      endcase
   endfunction
   assign nxt     = step(state);
   assign is_out  = state inside {OUT0, OUT1, OUT};
   assign cnt_inc = cnt + NW'(1);
   assign fin     = is_out && cnt_inc == n_reg;
   // Ra/Rb swap only after the OUT of an ADD/OUT pair, so the next ADD targets the older term.
   assign ra_n    = state == OUT ? rb : ra;
   assign rb_n    = state == OUT ? ra : rb;
   assign instr_valid = ins.v;
   assign opcode      = ins.op;
   assign operand1    = ins.a;
   assign operand2    = ins.b;
   assign load_value  = ins.ld;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ins   <= '0;
         n_reg <= '0;
         cnt   <= '0;
         ra    <= R0;
         rb    <= R1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               n_reg <= n;
               cnt   <= '0;
               ra    <= R0;
               rb    <= R1;
               busy  <= 1'b1;
               if (n == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state <= LD0;
                  ins   <= emit(LD0, R0, R1);
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: if (ready) begin
               ra <= ra_n;
               rb <= rb_n;
               if (is_out) cnt <= cnt_inc;
               if (fin) begin
                  state <= DONE;
                  done  <= 1'b1;
                  ins   <= '0;
               end else begin
                  state <= nxt;
                  ins   <= emit(nxt, ra_n, rb_n);
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fibo_sequencer.sv
// tb_fibo_sequencer: directed and randomized runs checked against an expected instruction list and a register-file model.
module tb_fibo_sequencer;
   localparam int SIZE = 4;
   localparam int NW   = 8;
   localparam logic [2:0] T_ADD = 3'b001, T_LOAD = 3'b100, T_OUT = 3'b101;
   typedef struct packed {
      logic [2:0]    op;
      logic [1:0]    a;
      logic [1:0]    b;
      logic [NW-1:0] ld;
   } ins_t;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b0;
   logic [NW-1:0] n = '0;
   logic instr_valid, busy, done;
   logic [SIZE-2:0] opcode;
   logic [SIZE-3:0] operand1, operand2;
   logic [NW-1:0] load_value;
   int checks = 0, errors = 0;
   fibo_sequencer #(.SIZE(SIZE), .NW(NW)) dut (
      .clk(clk), .rst(rst), .start(start), .n(n), .ready(ready),
      .instr_valid(instr_valid), .opcode(opcode), .operand1(operand1), .operand2(operand2),
      .load_value(load_value), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic idle_chk(input string tag);
      chk({tag, "_valid"}, instr_valid, 0);
      chk({tag, "_instr"}, {opcode, operand1, operand2, load_value}, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask
   // mode: 100 = ready always high, 1..99 = random ready percentage, -1 = hold the first ADD for 3 cycles
   task automatic run(input int nn, input int mode, input int poke_cyc);
      ins_t q[$];
      ins_t cur, prev;
      logic [63:0] fib[$];
      logic [63:0] rf[2];
      logic [1:0] a, b, t;
      int acc = 0, outs = 0, stall = 0, done_cyc = -1, first_cyc = -1, len;
      bit pv = 0, pr = 0, busy_ok = 1;
      prev = '0;
      rf[0] = 0;
      rf[1] = 0;
      if (nn > 0) begin
         q.push_back({T_LOAD, 2'd0, 2'd0, NW'(0)});
         q.push_back({T_LOAD, 2'd1, 2'd0, NW'(1)});
         q.push_back({T_OUT, 2'd0, 2'd0, NW'(0)});
      end
      if (nn > 1) q.push_back({T_OUT, 2'd1, 2'd0, NW'(0)});
      a = 0;
      b = 1;
      for (int k = 3; k <= nn; k++) begin
         q.push_back({T_ADD, a, b, NW'(0)});
         q.push_back({T_OUT, a, 2'd0, NW'(0)});
         t = a; a = b; b = t;
      end
      len = q.size();
      fib.push_back(0);
      fib.push_back(1);
      for (int i = 2; i <= nn; i++) fib.push_back(fib[i-1] + fib[i-2]);
      @(negedge clk);
      start = 1;
      n = NW'(nn);
      for (int cyc = 1; cyc <= 5000; cyc++) begin
         @(negedge clk);
         start = 0;
         n = NW'($urandom);
         cur = {opcode, operand1, operand2, load_value};
         busy_ok &= busy;
         if (pv && !pr) chk("stable", cur, prev);
         if (done) begin
            done_cyc = cyc;
            chk("done_no_valid", instr_valid, 0);
            break;
         end
         if (instr_valid && first_cyc < 0) first_cyc = cyc;
         if (mode == -1) begin
            ready = !(instr_valid && opcode == T_ADD && stall < 3);
            if (!ready) stall++;
         end else ready = mode >= 100 || $urandom_range(99) < mode;
         if (instr_valid && ready) begin
            if (q.size() == 0) chk("extra_instr", cur, 0);
            else chk("instr", cur, q.pop_front());
            if (cur.op == T_LOAD) rf[cur.a[0]] = 64'(cur.ld);
            else if (cur.op == T_ADD) rf[cur.a[0]] = rf[cur.a[0]] + rf[cur.b[0]];
            else if (cur.op == T_OUT) begin
               chk("out_value", rf[cur.a[0]], outs < fib.size() ? fib[outs] : 64'hdead);
               outs++;
            end
            acc++;
         end
         pv = instr_valid;
         pr = ready;
         prev = cur;
         if (cyc == poke_cyc || (mode > 0 && mode < 100 && $urandom_range(7) == 0)) begin
            start = 1;
            n = 2;
         end
      end
      start = 0;
      ready = 0;
      chk("done_seen", done_cyc > 0, 1);
      chk("instr_count", acc, len);
      chk("out_count", outs, nn);
      chk("busy_held", busy_ok, 1);
      if (mode == 100) begin
         chk("first_latency", first_cyc, nn > 0 ? 1 : -1);
         chk("done_cycle", done_cyc, len + 1);
      end
      @(negedge clk);
      idle_chk("post_done");
   endtask
   initial begin
      rst = 1;
      repeat (2) @(negedge clk);
      start = 1;
      ready = 1;
      n = 5;
      @(negedge clk);
      idle_chk("reset");
      rst = 0;
      start = 0;
      @(negedge clk);
      idle_chk("idle");
      run(5, 100, 0);
      run(0, 100, 0);
      run(1, 100, 0);
      run(5, -1, 0);
      run(5, 100, 3);
      // abort an n=5 run in its fourth cycle
      @(negedge clk);
      start = 1;
      n = 5;
      ready = 1;
      repeat (4) @(negedge clk) start = 0;
      chk("pre_abort_valid", instr_valid, 1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      idle_chk("abort");
      @(negedge clk);
      idle_chk("abort_no_done");
      run(2, 100, 0);
      run(255, 100, 0);
      for (int r = 0; r < 8; r++) run(int'($urandom_range(12)), int'($urandom_range(90, 40)), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
